ssd_io_regs: RTL and testbench
==============================

# ssd_io_regs

Memory-mapped register slave on the MicroBlaze MCS IO bus that holds the eight-digit seven-segment display state. It drives the display wrapper directly: `data_out` feeds its 32-bit hex data input and `control_out` feeds its 9-bit control input (`[7:0]` decimal points, `[8]` blank). It also adds a hardware blink function, so software can flash the display without polling.

## Interface

Parameters:
- `CLK_FREQUENCY`, default 100_000_000 — clock rate in Hz. The millisecond tick period is `CLK_FREQUENCY/1000` cycles.
- `BASE_ADDR`, default 32'hC000_0000 — byte address of register 0. Must be 16-byte aligned.

Ports (name, direction, width, meaning):
- `clk` in 1 — system clock. Single clock domain.
- `rst_n` in 1 — reset. Asynchronous assertion, active-low.
- `io_addr_strobe` in 1 — one-cycle pulse that starts a bus access.
- `io_read_strobe` in 1 — qualifies the access as a read.
- `io_write_strobe` in 1 — qualifies the access as a write.
- `io_address` in 32 — byte address.
- `io_byte_enable` in 4 — write byte lanes.
- `io_write_data` in 32 — write data.
- `io_read_data` out 32 — read data. Valid only while `io_ready` is high; 0 otherwise.
- `io_ready` out 1 — one-cycle completion pulse.
- `data_out` out 32 — display digits, one nibble per digit. Goes to the wrapper's data input.
- `control_out` out 9 — `{blank, dp[7:0]}`. Goes to the wrapper's control input.

## Operation

- Decode:
  - A hit requires `io_addr_strobe` high and `io_address[31:4] == BASE_ADDR[31:4]`.
  - The register is selected by `io_address[3:2]`.
  - On a miss: no response and no state change.
- Register map (offset: name, reset value):
  - 0x0: DATA, 0. Fully writable; read returns DATA.
  - 0x4: CTRL, 9'h100 (blanked, no dp). Bits `[8:0]` are writable; read returns them zero-extended.
  - 0x8: BLINK, 0. Bits `[15:0]` hold the blink half-period in ms. 0 disables blink.
  - 0xC: STATUS, read-only. Bit 0 = blink phase (1 = off phase). Bits `[31:16]` = free-running ms counter, which wraps at 16'hFFFF. Writes are ignored but still acknowledged.
- Byte enables:
  - Each byte lane is written only when its enable is set.
  - Lanes above a register's implemented width are discarded.
- Blink:
  - A ms prescaler counts 0 to `CLK_FREQUENCY/1000-1` and pulses `tick` on wrap.
  - While BLINK ≠ 0: a half-period counter increments on each `tick`. When it reaches BLINK it clears to 0 and toggles phase.
  - While BLINK = 0: phase is forced to 0 and the half-period counter is held at 0.
  - Any write to BLINK, including a partial-lane write, clears the half-period counter and phase to 0 in the same cycle. The new period is then timed from the point of the write.
- Outputs:
  - `data_out` = DATA.
  - `control_out[7:0]` = CTRL[7:0].
  - `control_out[8]` = CTRL[8] | phase.
  - Both outputs are registered and do not glitch on unrelated bus accesses.
- If read and write strobes are both high on the same hit, the write takes priority. The read data is then 0.

## Timing

- Bus latency:
  - `io_ready` is high exactly one cycle after a hit strobe, for exactly one cycle.
  - `io_read_data` is presented in that same cycle.
- Write visibility:
  - The register updates on the same edge that raises `io_ready`.
  - `data_out` and `control_out` reflect the new value in the `io_ready` cycle.
- Back-to-back accesses:
  - A new hit strobe in the same cycle as `io_ready` is accepted.
  - Its `io_ready` follows one cycle later.
  - Throughput is one access per cycle.
- Blink timing:
  - With BLINK = N, phase toggles every N × `CLK_FREQUENCY/1000` cycles after the write (±1 prescaler period, because the prescaler is not cleared).
- Reset:
  - Asserting `rst_n` low at any time, including mid-access, immediately returns every register, counter and phase to its reset value.
  - It also forces `io_ready` to 0 and `io_read_data` to 0. Any pending access is dropped.
- Output reset values:
  - `data_out` = 0
  - `control_out` = 9'h100
  - `io_ready` = 0
  - `io_read_data` = 0

## Structure

- Shared package holds:
  - register offsets (`REG_DATA`, `REG_CTRL`, `REG_BLINK`, `REG_STATUS`),
  - reset constants (`CTRL_RESET` = 9'h100),
  - the control field positions (`CTRL_BLANK_BIT` = 8).
- One sub-module, `ms_tick_gen`: the parameterised prescaler that produces the one-cycle `tick` pulse. It is reusable by other MCS peripherals.
- Decode, register file and blink logic stay in the top module.

## Test plan

Bench conditions: `CLK_FREQUENCY` = 10_000 (10 cycles/ms), `BASE_ADDR` = 32'hC000_0000.

1. **Reset values:** after reset release, `control_out` = 9'h100, `data_out` = 0, `io_ready` = 0. Then read 0x4 → `io_ready` one cycle later with data 32'h100.
2. **Full write and readback:** write 32'h1234_ABCD to 0x0 with byte enables 4'hF → `data_out` = 32'h1234ABCD in the `io_ready` cycle; read 0x0 returns the same value.
3. **Partial write:** write 32'hFFFF_FF5A to 0x4 with byte enables 4'b0001 → `control_out` = 9'h15A (blank kept). Then write with byte enables 4'b0010 and data 32'h0 → `control_out` = 9'h05A.
4. **Blink:** with CTRL = 9'h000, write BLINK = 3 → `control_out[8]` toggles every 30 cycles (±10). Write BLINK = 0 → `control_out[8]` = 0 the next cycle and stays 0.
5. **Decode and back-to-back:** an access to 32'hC000_0010 gets no `io_ready` and changes no state. Back-to-back writes to 0x0 and 0x8 on consecutive cycles produce two consecutive `io_ready` pulses.
6. **Reset mid-operation:** assert `rst_n` low in the `io_ready` cycle of a read while blink is active → `io_ready` and `io_read_data` drop to 0 and `control_out` = 9'h100 without waiting for a clock edge; blink stays disabled after release.

Source files
------------

// File: rtl/ssd_io_regs_pkg.sv
// ssd_io_regs_pkg: register map, reset constants and byte-lane merge helper for ssd_io_regs
package ssd_io_regs_pkg;
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_BLINK  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;
  localparam logic [8:0] CTRL_RESET = 9'h100;
  localparam int CTRL_BLANK_BIT = 8;
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wdat, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? wdat[8*i+:8] : cur[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler emitting a one-cycle tick every DIV cycles
module ms_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ssd_io_regs.sv
// ssd_io_regs: MCS IO-bus register slave holding seven-segment display state with hardware blink
module ssd_io_regs
  import ssd_io_regs_pkg::*;
#(
  parameter int          CLK_FREQUENCY = 100_000_000,
  parameter logic [31:0] BASE_ADDR     = 32'hC000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic [31:0] data_out,
  output logic [8:0]  control_out
);
  logic        tick;
  logic [8:0]  ctrl_r, ctrl_nx;
  logic [15:0] blink_r, hp_cnt, hp_nx, ms_cnt;
  logic        phase, phase_nx;
  logic        hit, wr, rd, blink_wr, hp_wrap, blink_off;
  reg_sel_e    sel;
  logic [31:0] wmerge, rdata;
  logic        unused;
  assign unused = ^io_address[1:0];

  ms_tick_gen #(.DIV(CLK_FREQUENCY / 1000)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    hit = io_addr_strobe && io_address[31:4] == BASE_ADDR[31:4];
    wr = hit && io_write_strobe;
    rd = hit && io_read_strobe && !io_write_strobe;
    sel = reg_sel_e'(io_address[3:2]);
    wmerge = merge_bytes(sel == REG_DATA ? data_out : sel == REG_CTRL ? {23'b0, ctrl_r} : {16'b0, blink_r},
                         io_write_data, io_byte_enable);
    rdata = sel == REG_DATA ? data_out :
            sel == REG_CTRL ? {23'b0, ctrl_r} :
            sel == REG_BLINK ? {16'b0, blink_r} : {ms_cnt, 15'b0, phase};
    ctrl_nx = (wr && sel == REG_CTRL) ? wmerge[8:0] : ctrl_r;
    blink_wr = wr && sel == REG_BLINK;
    // a BLINK write restarts timing so the new period counts from the write
    blink_off = blink_wr || blink_r == 16'd0;
    hp_wrap = ({1'b0, hp_cnt} + 17'd1) >= {1'b0, blink_r};
    hp_nx = blink_off ? 16'd0 : tick ? (hp_wrap ? 16'd0 : hp_cnt + 16'd1) : hp_cnt;
    phase_nx = blink_off ? 1'b0 : (tick && hp_wrap) ? ~phase : phase;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out     <= '0;
      ctrl_r       <= CTRL_RESET;
      blink_r      <= '0;
      hp_cnt       <= '0;
      phase        <= 1'b0;
      ms_cnt       <= '0;
      io_ready     <= 1'b0;
      io_read_data <= '0;
      control_out  <= CTRL_RESET;
    end else begin
      io_ready     <= hit;
      io_read_data <= rd ? rdata : '0;
      if (wr && sel == REG_DATA) data_out <= wmerge;
      ctrl_r       <= ctrl_nx;
      if (blink_wr) blink_r <= wmerge[15:0];
      hp_cnt       <= hp_nx;
      phase        <= phase_nx;
      ms_cnt       <= ms_cnt + 16'(tick);
      control_out  <= {ctrl_nx[CTRL_BLANK_BIT] | phase_nx, ctrl_nx[7:0]};
    end
endmodule

// File: tb/tb_ssd_io_regs.sv
// tb_ssd_io_regs: directed and randomized checks of ssd_io_regs against a cycle-count based model
module tb_ssd_io_regs;
  localparam logic [31:0] BASE = 32'hC000_0000;
  logic        clk, rst_n;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_address, io_write_data, io_read_data, data_out;
  logic [3:0]  io_byte_enable;
  logic        io_ready;
  logic [8:0]  control_out;
  int npass, nfail, ntot, edges;
  logic [31:0] m_data;
  logic [8:0]  m_ctrl;
  logic [15:0] m_blink;
  int          m_w;

  ssd_io_regs #(.CLK_FREQUENCY(10_000), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address), .io_byte_enable(io_byte_enable),
    .io_write_data(io_write_data), .io_read_data(io_read_data), .io_ready(io_ready),
    .data_out(data_out), .control_out(control_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clock edges since reset release; every 10th edge consumes a ms tick
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;

  function automatic logic ph(int e);
    int k;
    if (m_blink == 16'd0) return 1'b0;
    k = e / 10 - m_w / 10;
    return ((k / int'(m_blink)) % 2) == 1;
  endfunction

  function automatic logic [15:0] ms_at(int e);
    return 16'((e / 10) % 65536);
  endfunction

  function automatic logic [8:0] exp_ctl();
    return {m_ctrl[8] | ph(edges), m_ctrl[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_ctrl = 9'h100; m_blink = '0; m_w = 0;
  endtask

  task automatic model_write(input logic [1:0] s, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] cur;
    cur = s == 2'd0 ? m_data : s == 2'd1 ? {23'b0, m_ctrl} : {16'b0, m_blink};
    for (int i = 0; i < 4; i++) if (be[i]) cur[8*i+:8] = wd[8*i+:8];
    if (s == 2'd0) m_data = cur;
    if (s == 2'd1) m_ctrl = cur[8:0];
    if (s == 2'd2) begin
      m_blink = cur[15:0];
      m_w = edges;
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    io_addr_strobe = 1'b1; io_read_strobe = !we; io_write_strobe = we;
    io_address = addr; io_byte_enable = be; io_write_data = wd;
  endtask

  task automatic release_bus();
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
  endtask

  task automatic acc(input logic we, input logic [3:0] off, input logic [3:0] be, input logic [31:0] wd);
    logic [1:0]  s;
    logic [31:0] erd;
    s = off[3:2];
    @(negedge clk);
    drive(we, BASE | {28'h0, off}, be, wd);
    @(negedge clk);
    release_bus();
    erd = s == 2'd0 ? m_data : s == 2'd1 ? {23'b0, m_ctrl} : s == 2'd2 ? {16'b0, m_blink} :
          {ms_at(edges - 1), 15'b0, ph(edges - 1)};
    if (we) begin
      erd = '0;
      model_write(s, be, wd);
    end
    chk("ready", io_ready, 1);
    chk("rdata", io_read_data, erd);
    chk("data_out", data_out, m_data);
    chk("control_out", control_out, exp_ctl());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", io_ready, 0);
      chk("idle_data", data_out, m_data);
      chk("idle_ctl", control_out, exp_ctl());
    end
  endtask

  initial begin
    npass = 0; nfail = 0; ntot = 0;
    rst_n = 1'b0;
    release_bus();
    io_address = '0; io_byte_enable = '0; io_write_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ctl", control_out, 9'h100);
    chk("rst_data", data_out, 0);
    chk("rst_ready", io_ready, 0);
    chk("rst_rdata", io_read_data, 0);
    rst_n = 1'b1;
    idle(2);
    acc(1'b0, 4'h4, 4'h0, 0);
    chk("ctrl_read", io_read_data, 32'h100);

    acc(1'b1, 4'h0, 4'hF, 32'h1234_ABCD);
    chk("full_wr", data_out, 32'h1234_ABCD);
    acc(1'b0, 4'h0, 4'h0, 0);
    chk("full_rd", io_read_data, 32'h1234_ABCD);

    acc(1'b1, 4'h4, 4'b0001, 32'hFFFF_FF5A);
    chk("part_lo", control_out, 9'h15A);
    acc(1'b1, 4'h4, 4'b0010, 32'h0);
    chk("part_hi", control_out, 9'h05A);

    acc(1'b1, 4'h4, 4'b0011, 32'h0);
    acc(1'b1, 4'h8, 4'hF, 32'd3);
    idle(100);
    acc(1'b1, 4'h8, 4'hF, 32'd0);
    chk("blink_off", control_out[8], 0);
    idle(30);

    // decode miss: one past the 16-byte window
    @(negedge clk);
    drive(1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    release_bus();
    chk("miss_ready", io_ready, 0);
    chk("miss_data", data_out, m_data);
    idle(1);

    // back-to-back writes to DATA then BLINK
    @(negedge clk);
    drive(1'b1, BASE, 4'hF, 32'hCAFE_0001);
    @(negedge clk);
    model_write(2'd0, 4'hF, 32'hCAFE_0001);
    chk("b2b_ready0", io_ready, 1);
    chk("b2b_data", data_out, 32'hCAFE_0001);
    drive(1'b1, BASE + 32'h8, 4'h3, 32'd2);
    @(negedge clk);
    release_bus();
    model_write(2'd2, 4'h3, 32'd2);
    chk("b2b_ready1", io_ready, 1);
    chk("b2b_ctl", control_out, exp_ctl());
    idle(45);

    // reset in the ready cycle of a read with blink running
    @(negedge clk);
    drive(1'b0, BASE + 32'hC, 4'h0, 0);
    @(posedge clk);
    #1;
    chk("mid_ready_hi", io_ready, 1);
    rst_n = 1'b0;
    release_bus();
    #1;
    chk("mid_ready", io_ready, 0);
    chk("mid_rdata", io_read_data, 0);
    chk("mid_ctl", control_out, 9'h100);
    chk("mid_data", data_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    acc(1'b0, 4'h8, 4'h0, 0);
    chk("post_blink", io_read_data, 0);
    acc(1'b1, 4'h4, 4'h3, 32'h0);
    idle(35);
    acc(1'b0, 4'hC, 4'h0, 0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] wd;
      logic [3:0]  off;
      off = {2'($urandom_range(0, 3)), 2'b00};
      wd = $urandom;
      if (off == 4'h8) wd[15:0] = 16'($urandom_range(0, 4));
      acc(1'($urandom_range(0, 1)), off, 4'($urandom), wd);
      idle($urandom_range(0, 12));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
